entropy_collector: RTL

Consumer end of the entropy source interface (`entropy_enabled` / `entropy_data` / `entropy_valid` / `entropy_ack`). The block pulls 32-bit words from one entropy source with a valid/ack handshake and assembles NUM_WORDS of them into one block for the mixer. It runs a repetition-count health test on every accepted word. It sits between a source (e.g. rosc/avalanche entropy) and the trng mixer.

---
 rtl/trng_defines.sv | 33 +++
 rtl/entropy_rep_test.sv | 61 ++++++
 rtl/entropy_collector.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/trng_defines.sv
// trng_defines: constants shared by the entropy collector and the TRNG
// debug/status readout.
//   WORD_W           width of one entropy word
//   DEF_NUM_WORDS    default number of words per assembled block
//   DEF_REP_LIMIT    default repetition-count trip threshold
//   ST_*             3-bit collector state encodings (visible on status readout)
//   sat_inc32        saturating increment for the 32-bit word counter
package trng_defines;

  localparam int WORD_W        = 32;
  localparam int DEF_NUM_WORDS = 16;
  localparam int DEF_REP_LIMIT = 8;

  typedef logic [2:0] coll_state_t;

  localparam coll_state_t ST_IDLE    = 3'd0;
  localparam coll_state_t ST_COLLECT = 3'd1;
  localparam coll_state_t ST_WAIT    = 3'd2;
  localparam coll_state_t ST_FULL    = 3'd3;
  localparam coll_state_t ST_ERROR   = 3'd4;

  // Counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/entropy_rep_test.sv
// entropy_rep_test: repetition-count health test on accepted entropy words.
//   clk, reset_n  clock, asynchronous active-low reset
//   sample        strobe: data is being accepted this cycle
//   clear         synchronous flush of the test history (wins over sample)
//   data          word being accepted
//   trip          high in the sampling cycle when this word makes the run of
//                 identical words reach REP_LIMIT
module entropy_rep_test
  import trng_defines::*;
#(
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample,
  input  logic              clear,
  input  logic [WORD_W-1:0] data,
  output logic              trip
);

  localparam logic [7:0] REP_LIMIT_C = 8'(REP_LIMIT);

  logic [WORD_W-1:0] last_word_r;
  logic              last_valid_r;
  logic [7:0]        rep_ctr_r;
  logic [7:0]        rep_next_s;

  // Run length including the word currently offered; trip is decided on it so
  // the top can route the tripping sample straight to the error state.
  always_comb begin
    rep_next_s = 8'd1;
    if (last_valid_r && (data == last_word_r)) begin
      if (rep_ctr_r != 8'hFF) begin
        rep_next_s = rep_ctr_r + 8'd1;
      end else begin
        rep_next_s = rep_ctr_r;
      end
    end else begin
      rep_next_s = 8'd1;
    end
    trip = sample && !clear && (rep_next_s >= REP_LIMIT_C);
  end

  // History registers: last accepted word, its valid flag and the run length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_word_r  <= {WORD_W{1'b0}};
      last_valid_r <= 1'b0;
      rep_ctr_r    <= 8'd0;
    end else if (clear) begin
      last_word_r  <= {WORD_W{1'b0}};
      last_valid_r <= 1'b0;
      rep_ctr_r    <= 8'd0;
    end else if (sample) begin
      last_word_r  <= data;
      last_valid_r <= 1'b1;
      rep_ctr_r    <= rep_next_s;
    end
  end

endmodule

// File: rtl/entropy_collector.sv
// entropy_collector: pulls 32-bit words from an entropy source with a
// valid/ack handshake and assembles NUM_WORDS of them into one block.
//   clk, reset_n                 clock, asynchronous active-low reset
//   enable                       collection allowed
//   discard                      synchronous flush: drop block, clear error
//   entropy_enabled/_valid/_data source side; ack pulses one cycle per word
//   block_data/_valid/_ack       mixer side; first word in the MS 32 bits
//   security_error               sticky repetition-test failure
//   words_collected              saturating count of accepted words
module entropy_collector
  import trng_defines::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        discard,
  input  logic                        entropy_enabled,
  input  logic [WORD_W-1:0]           entropy_data,
  input  logic                        entropy_valid,
  output logic                        entropy_ack,
  output logic [WORD_W*NUM_WORDS-1:0] block_data,
  output logic                        block_valid,
  input  logic                        block_ack,
  output logic                        security_error,
  output logic [WORD_W-1:0]           words_collected
);

  localparam int         BLK_W       = WORD_W * NUM_WORDS;
  localparam logic [7:0] NUM_WORDS_C = 8'(NUM_WORDS);

  coll_state_t       state_r;
  coll_state_t       state_next_s;
  logic [7:0]        word_ctr_r;
  logic [7:0]        word_inc_s;
  logic              sample_s;
  logic              release_s;
  logic              block_done_s;
  logic              trip_s;
  logic              ack_r;
  logic [BLK_W-1:0]  block_r;
  logic              block_valid_r;
  logic              sec_err_r;
  logic [WORD_W-1:0] words_r;

  entropy_rep_test #(
    .REP_LIMIT (REP_LIMIT)
  ) u_rep_test (
    .clk     (clk),
    .reset_n (reset_n),
    .sample  (sample_s),
    .clear   (discard),
    .data    (entropy_data),
    .trip    (trip_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; discard overrides everything, a trip overrides FULL.
  always_comb begin
    state_next_s = state_r;
    if (discard) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) state_next_s = ST_COLLECT;
          else        state_next_s = ST_IDLE;
        end
        ST_COLLECT: begin
          if (!enable)           state_next_s = ST_IDLE;
          else if (!sample_s)    state_next_s = ST_COLLECT;
          else if (trip_s)       state_next_s = ST_ERROR;
          else if (block_done_s) state_next_s = ST_FULL;
          else                   state_next_s = ST_WAIT;
        end
        ST_WAIT:  state_next_s = ST_COLLECT;
        ST_FULL: begin
          if (!block_ack)  state_next_s = ST_FULL;
          else if (enable) state_next_s = ST_COLLECT;
          else             state_next_s = ST_IDLE;
        end
        ST_ERROR: state_next_s = ST_ERROR;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // Decoded strobes; a disabled source looks exactly like an invalid word.
  always_comb begin
    sample_s     = (state_r == ST_COLLECT) && enable && entropy_enabled &&
                   entropy_valid && !discard;
    release_s    = (state_r == ST_FULL) && block_ack && !discard;
    word_inc_s   = word_ctr_r + 8'd1;
    block_done_s = (word_inc_s == NUM_WORDS_C);
  end

  // Datapath: shift buffer, counters and the registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_r         <= 1'b0;
      block_r       <= {BLK_W{1'b0}};
      block_valid_r <= 1'b0;
      sec_err_r     <= 1'b0;
      words_r       <= {WORD_W{1'b0}};
      word_ctr_r    <= 8'd0;
    end else if (discard) begin
      ack_r         <= 1'b0;
      block_r       <= {BLK_W{1'b0}};
      block_valid_r <= 1'b0;
      sec_err_r     <= 1'b0;
      word_ctr_r    <= 8'd0;
    end else if (sample_s) begin
      ack_r   <= 1'b1;
      words_r <= sat_inc32(words_r);
      if (trip_s) begin
        // The tripping word is still acked but never reaches the mixer.
        sec_err_r     <= 1'b1;
        block_r       <= {BLK_W{1'b0}};
        block_valid_r <= 1'b0;
        word_ctr_r    <= 8'd0;
      end else begin
        block_r    <= {block_r[BLK_W-WORD_W-1:0], entropy_data};
        word_ctr_r <= word_inc_s;
        if (block_done_s) begin
          block_valid_r <= 1'b1;
        end
      end
    end else begin
      ack_r <= 1'b0;
      if (release_s) begin
        word_ctr_r    <= 8'd0;
        block_valid_r <= 1'b0;
      end
    end
  end

  assign entropy_ack     = ack_r;
  assign block_data      = block_r;
  assign block_valid     = block_valid_r;
  assign security_error  = sec_err_r;
  assign words_collected = words_r;

endmodule
